// File: rtl/load_imm_ext_pkg.sv
// ---------------------------------------------------------------------------
// load_imm_ext_pkg
// Shared definitions for the load/immediate extension unit.
//   mode_t       : 3-bit operation select carried on in_mode
//   MODE_*       : operation encodings (load lanes and immediate forms)
//   clog2()      : elaboration-time log2, used to size the byte-offset field
// ---------------------------------------------------------------------------
package load_imm_ext_pkg;

  typedef logic [2:0] mode_t;

  // Load-lane operations (byte offset taken from in_off)
  localparam mode_t MODE_SB    = 3'd0;  // sign-extended byte
  localparam mode_t MODE_SH    = 3'd1;  // sign-extended halfword
  localparam mode_t MODE_W     = 3'd2;  // full datapath word
  // Immediate operations (in_off ignored)
  localparam mode_t MODE_IMM_S = 3'd3;  // sign-extended immediate
  // Zero-extending load lanes
  localparam mode_t MODE_ZB    = 3'd4;  // zero-extended byte
  localparam mode_t MODE_ZH    = 3'd5;  // zero-extended halfword
  // More immediate operations
  localparam mode_t MODE_IMM_Z = 3'd6;  // zero-extended immediate
  localparam mode_t MODE_IMM_U = 3'd7;  // upper (LUI-style) immediate

  // Ceiling log2 for positive values; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/load_imm_ext_ext_core.sv
// ---------------------------------------------------------------------------
// load_imm_ext_ext_core
// Purely combinational decode + extension datapath.
//   mode   : operation select (mode_t)
//   off    : byte offset of the load within the word
//   data   : memory word, or immediate in data[IMM_WIDTH-1:0]
//   err    : misaligned access (halfword on odd offset, word on nonzero offset)
//   result : extended value; forced to zero whenever err is set
// ---------------------------------------------------------------------------
module load_imm_ext_ext_core
  import load_imm_ext_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  IMM_WIDTH  = 16,
  localparam int OFF_WIDTH  = clog2(DATA_WIDTH / 8)
) (
  input  mode_t                 mode,
  input  logic [OFF_WIDTH-1:0]  off,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result
);

  // Little-endian lane pick: byte lane k lives at data[8k+7:8k]; the
  // halfword lane index drops the low offset bit.
  logic [OFF_WIDTH+2:0]  byte_pos;
  logic [OFF_WIDTH+2:0]  half_pos;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_z;
  logic [DATA_WIDTH-1:0] imm_u;

  assign byte_pos = {off, 3'b000};
  assign half_pos = {off[OFF_WIDTH-1:1], 4'b0000};
  assign lane_b   = data[byte_pos +: 8];
  assign lane_h   = data[half_pos +: 16];

  assign imm_s = {{(DATA_WIDTH-IMM_WIDTH){data[IMM_WIDTH-1]}}, data[IMM_WIDTH-1:0]};
  assign imm_z = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, data[IMM_WIDTH-1:0]};

  // Upper immediate: on a 32-bit datapath the immediate fills the top bits.
  // On a 64-bit datapath it behaves like MIPS64 LUI: shift left by 16 into a
  // 32-bit value, then sign-extend from bit 31.
  generate
    if (DATA_WIDTH == 32) begin : g_upper32
      assign imm_u = {data[IMM_WIDTH-1:0], {(DATA_WIDTH-IMM_WIDTH){1'b0}}};
    end else begin : g_upper64
      logic [31:0] upper32;
      if (IMM_WIDTH >= 16) begin : g_wide_imm
        assign upper32 = {data[15:0], 16'h0000};
      end else begin : g_narrow_imm
        assign upper32 = {{(16-IMM_WIDTH){1'b0}}, data[IMM_WIDTH-1:0], 16'h0000};
      end
      assign imm_u = {{(DATA_WIDTH-32){upper32[31]}}, upper32};
    end
  endgenerate

  always_comb begin
    err    = 1'b0;
    result = '0;
    case (mode)
      MODE_SB: result = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      MODE_ZB: result = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      MODE_SH: begin
        if (off[0]) err = 1'b1;
        else        result = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      end
      MODE_ZH: begin
        if (off[0]) err = 1'b1;
        else        result = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      end
      MODE_W: begin
        if (off != '0) err = 1'b1;
        else           result = data;
      end
      MODE_IMM_S: result = imm_s;
      MODE_IMM_Z: result = imm_z;
      MODE_IMM_U: result = imm_u;
      default: begin
        err    = 1'b0;
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/load_imm_ext.sv
// ---------------------------------------------------------------------------
// load_imm_ext
// Registered multi-mode extension unit: immediate extension (sign / zero /
// upper) and load-lane extraction with sign or zero extension.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready is a register)
//   in_mode, in_off       : operation select and byte offset
//   in_data               : memory word or immediate (low IMM_WIDTH bits)
//   out_valid / out_ready : output handshake
//   out_data, out_err     : extended result and misalignment flag,
//                           both qualified by out_valid
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; this unit holds out_data/out_err stable while
// out_valid && !out_ready. in_valid may wait on in_ready; in_ready never
// depends combinationally on out_ready.
//
// Storage is an output register plus a one-entry skid register. in_ready is
// the registered "skid empty" flag, so a word accepted during a stall always
// has somewhere to go. Result latency is one cycle; throughput one per cycle.
// ---------------------------------------------------------------------------
module load_imm_ext
  import load_imm_ext_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  IMM_WIDTH  = 16,
  localparam int OFF_WIDTH  = clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  mode_t                 in_mode,
  input  logic [OFF_WIDTH-1:0]  in_off,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  // Combinational extension of the incoming word
  logic                  core_err;
  logic [DATA_WIDTH-1:0] core_data;

  load_imm_ext_ext_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH)
  ) u_core (
    .mode   (in_mode),
    .off    (in_off),
    .data   (in_data),
    .err    (core_err),
    .result (core_data)
  );

  // Skid register state
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_err;

  // Next-state values
  logic                  out_valid_nx;
  logic [DATA_WIDTH-1:0] out_data_nx;
  logic                  out_err_nx;
  logic                  skid_valid_nx;
  logic [DATA_WIDTH-1:0] skid_data_nx;
  logic                  skid_err_nx;
  logic                  in_ready_nx;

  logic in_fire;
  logic out_free;

  assign in_fire  = in_valid && in_ready;
  // Output register can take a new entry this edge if empty or draining
  assign out_free = !out_valid || out_ready;

  always_comb begin
    out_valid_nx  = out_valid;
    out_data_nx   = out_data;
    out_err_nx    = out_err;
    skid_valid_nx = skid_valid;
    skid_data_nx  = skid_data;
    skid_err_nx   = skid_err;

    if (out_free) begin
      if (skid_valid) begin
        // Oldest entry is in the skid; move it forward. in_ready was low,
        // so no new word arrives on this edge.
        out_valid_nx  = 1'b1;
        out_data_nx   = skid_data;
        out_err_nx    = skid_err;
        skid_valid_nx = 1'b0;
      end else if (in_fire) begin
        out_valid_nx = 1'b1;
        out_data_nx  = core_data;
        out_err_nx   = core_err;
      end else begin
        out_valid_nx = 1'b0;
      end
    end else if (in_fire) begin
      // Output is stalled: park the new word in the skid register
      skid_valid_nx = 1'b1;
      skid_data_nx  = core_data;
      skid_err_nx   = core_err;
    end

    in_ready_nx = !skid_valid_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_nx;
      out_data   <= out_data_nx;
      out_err    <= out_err_nx;
      skid_valid <= skid_valid_nx;
      skid_data  <= skid_data_nx;
      skid_err   <= skid_err_nx;
      in_ready   <= in_ready_nx;
    end
  end

endmodule

// File: tb/tb_load_imm_ext.sv
// ---------------------------------------------------------------------------
// tb_load_imm_ext
// Directed bench for load_imm_ext at DATA_WIDTH=32 and DATA_WIDTH=64.
// Drivers push the hand-computed expected result into a queue when they
// issue a vector; per-instance monitors pop and compare on output transfers.
// ---------------------------------------------------------------------------
module tb_load_imm_ext;
  import load_imm_ext_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 32-bit instance ----------------
  logic        in_valid;
  logic        in_ready;
  mode_t       in_mode;
  logic [1:0]  in_off;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  load_imm_ext #(.DATA_WIDTH(32), .IMM_WIDTH(16)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_off    (in_off),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // ---------------- 64-bit instance ----------------
  logic        w_in_valid;
  logic        w_in_ready;
  mode_t       w_in_mode;
  logic [2:0]  w_in_off;
  logic [63:0] w_in_data;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_out_data;
  logic        w_out_err;

  load_imm_ext #(.DATA_WIDTH(64), .IMM_WIDTH(16)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_mode   (w_in_mode),
    .in_off    (w_in_off),
    .in_data   (w_in_data),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_data  (w_out_data),
    .out_err   (w_out_err)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic        exp_e_q[$];
  logic [63:0] exp64_q[$];
  logic        exp64_e_q[$];

  bit cnt_en    = 1'b0;
  int ready_low = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send32(input mode_t m, input logic [1:0] o, input logic [31:0] d,
                        input logic e, input logic [31:0] x);
    bit acc;
    exp_q.push_back(x);
    exp_e_q.push_back(e);
    in_mode  = m;
    in_off   = o;
    in_data  = d;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept32_timeout actual=no_accept required=accept data=0x%0h", d);
    end
  endtask

  task automatic send64(input mode_t m, input logic [2:0] o, input logic [63:0] d,
                        input logic e, input logic [63:0] x);
    bit acc;
    exp64_q.push_back(x);
    exp64_e_q.push_back(e);
    w_in_mode  = m;
    w_in_off   = o;
    w_in_data  = d;
    w_in_valid = 1'b1;
    acc        = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = w_in_ready;
      @(posedge clk);
      #1;
    end
    w_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept64_timeout actual=no_accept required=accept data=0x%0h", d);
    end
  endtask

  // ---------------- monitors ----------------
  // Compare every cycle the output is valid (so stalled outputs are checked
  // for stability against the queue head); pop only when the word transfers.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out32_spurious actual=0x%0h err=%0b required=no_output", out_data, out_err);
      end else begin
        if (out_data !== exp_q[0] || out_err !== exp_e_q[0]) begin
          failures++;
          $display("FAIL out32 actual=0x%0h err=%0b required=0x%0h err=%0b",
                   out_data, out_err, exp_q[0], exp_e_q[0]);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_e_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_out_valid) begin
      checks++;
      if (exp64_q.size() == 0) begin
        failures++;
        $display("FAIL out64_spurious actual=0x%0h err=%0b required=no_output", w_out_data, w_out_err);
      end else begin
        if (w_out_data !== exp64_q[0] || w_out_err !== exp64_e_q[0]) begin
          failures++;
          $display("FAIL out64 actual=0x%0h err=%0b required=0x%0h err=%0b",
                   w_out_data, w_out_err, exp64_q[0], exp64_e_q[0]);
        end
        if (w_out_ready) begin
          void'(exp64_q.pop_front());
          void'(exp64_e_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cnt_en && !in_ready) ready_low++;
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] LW = 32'h80FF_7F01;

  initial begin
    in_valid    = 1'b0;
    in_mode     = MODE_SB;
    in_off      = '0;
    in_data     = '0;
    out_ready   = 1'b1;
    w_in_valid  = 1'b0;
    w_in_mode   = MODE_SB;
    w_in_off    = '0;
    w_in_data   = '0;
    w_out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_err",   out_err,   0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid64", w_out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Immediates: result one cycle after the transfer
    send32(MODE_IMM_S, 2'd0, 32'h0000_8001, 1'b0, 32'hFFFF_8001);
    check("lat_imm_s", out_valid, 1);
    idle(1);
    send32(MODE_IMM_Z, 2'd3, 32'h0000_8001, 1'b0, 32'h0000_8001);
    check("lat_imm_z", out_valid, 1);
    idle(1);
    send32(MODE_IMM_U, 2'd1, 32'h0000_8001, 1'b0, 32'h8001_0000);
    check("lat_imm_u", out_valid, 1);
    idle(1);

    // Load lanes, back to back
    send32(MODE_SB, 2'd0, LW, 1'b0, 32'h0000_0001);
    send32(MODE_SB, 2'd1, LW, 1'b0, 32'h0000_007F);
    send32(MODE_SB, 2'd2, LW, 1'b0, 32'hFFFF_FFFF);
    send32(MODE_SB, 2'd3, LW, 1'b0, 32'hFFFF_FF80);
    send32(MODE_ZB, 2'd3, LW, 1'b0, 32'h0000_0080);
    send32(MODE_SH, 2'd2, LW, 1'b0, 32'hFFFF_80FF);
    send32(MODE_ZH, 2'd0, LW, 1'b0, 32'h0000_7F01);
    send32(MODE_ZH, 2'd2, LW, 1'b0, 32'h0000_80FF);

    // Misalignment
    send32(MODE_SH, 2'd1, LW, 1'b1, 32'h0000_0000);
    send32(MODE_ZH, 2'd3, LW, 1'b1, 32'h0000_0000);
    send32(MODE_W,  2'd2, LW, 1'b1, 32'h0000_0000);
    send32(MODE_W,  2'd0, LW, 1'b0, 32'h80FF_7F01);
    idle(2);

    // Backpressure: out_ready low for three edges while streaming 1..5
    out_ready = 1'b0;
    ready_low = 0;
    cnt_en    = 1'b1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    for (int v = 1; v <= 5; v++) begin
      send32(MODE_IMM_Z, 2'd0, 32'(v), 1'b0, 32'(v));
    end
    idle(4);
    cnt_en = 1'b0;
    check("in_ready_low_cycles", 64'(ready_low), 2);
    check("bp_drained", 64'(exp_q.size()), 0);

    // Reset with both entries occupied
    out_ready = 1'b0;
    send32(MODE_IMM_Z, 2'd0, 32'h0000_00AA, 1'b0, 32'h0000_00AA);
    send32(MODE_IMM_Z, 2'd0, 32'h0000_00BB, 1'b0, 32'h0000_00BB);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_e_q.delete();
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready",  in_ready,  1);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(3);
    check("post_rst_idle", out_valid, 0);
    send32(MODE_SB, 2'd1, 32'h0000_8000, 1'b0, 32'hFFFF_FF80);
    check("post_rst_first", out_valid, 1);
    idle(2);

    // 64-bit datapath
    send64(MODE_SB,    3'd7, 64'h8000_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    send64(MODE_IMM_U, 3'd0, 64'h0000_0000_0000_8000, 1'b0, 64'hFFFF_FFFF_8000_0000);
    send64(MODE_IMM_U, 3'd0, 64'h0000_0000_0000_1234, 1'b0, 64'h0000_0000_1234_0000);
    send64(MODE_IMM_S, 3'd5, 64'h0000_0000_0000_8000, 1'b0, 64'hFFFF_FFFF_FFFF_8000);
    send64(MODE_ZH,    3'd6, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0000_0000_0000_1234);
    send64(MODE_SH,    3'd3, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0000_0000_0000_0000);
    send64(MODE_W,     3'd4, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0000_0000_0000_0000);
    send64(MODE_W,     3'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h1234_5678_9ABC_DEF0);

    // Drain both scoreboards with a bounded wait
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp64_q.size() != 0); i++) idle(1);
    check("drain32", 64'(exp_q.size()), 0);
    check("drain64", 64'(exp64_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
